// File: rtl/coax_rx_frame_ctrl.sv
// Coax receive frame controller: frames receiver words, appends end/error markers,
// queues them in a first-word-fall-through FIFO and sequences receiver recovery.
module coax_rx_frame_ctrl #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TIMEOUT_CLOCKS = 256,
  parameter int unsigned RECOVER_CLOCKS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_active,
  input  logic                     rx_strobe,
  input  logic                     rx_error,
  input  logic [9:0]               rx_data,
  output logic                     rx_reset,
  input  logic                     rd_en,
  output logic [10:0]              rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CLOCKS + 1);
  localparam int unsigned RW = $clog2(RECOVER_CLOCKS + 1);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CLOCKS - 1);
  localparam logic [RW-1:0] RecoverLast = RW'(RECOVER_CLOCKS - 1);
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReceive, StRecover} state_e;

  state_e          state_q;
  logic            active_q;
  logic            rx_reset_q;
  logic [8:0]      word_cnt_q;
  logic [TW-1:0]   timer_q;
  logic [RW-1:0]   rec_cnt_q;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q;
  logic            overflow_q;
  logic [10:0]     mem [DEPTH];

  logic            rise, fall, timeout;
  logic            push_req, push_ok, pop;
  logic [10:0]     push_data;

  assign rise = rx_active & ~active_q;
  assign fall = ~rx_active & active_q;

  // Marker priority inside a frame: error, then frame end, then word, then timeout.
  always_comb begin
    push_req  = 1'b0;
    push_data = '0;
    timeout   = 1'b0;
    if (state_q == StReceive) begin
      if (rx_error) begin
        push_req  = 1'b1;
        push_data = {2'b11, 5'b0, rx_data[3:0]};
      end else if (fall) begin
        push_req  = 1'b1;
        push_data = {1'b1, 1'b0, word_cnt_q};
      end else if (rx_strobe) begin
        push_req  = 1'b1;
        push_data = {1'b0, rx_data};
      end else if (timer_q == TimerLast) begin
        timeout   = 1'b1;
        push_req  = 1'b1;
        push_data = {2'b11, 5'b0, 4'b1000};
      end
    end
  end

  assign empty    = (level_q == '0);
  assign pop      = rd_en & ~empty;
  assign push_ok  = push_req & ((level_q != LevelFull) | pop);
  assign rd_data  = empty ? 11'd0 : mem[rptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;
  // Reset request covers the reset cycles themselves plus one trailing cycle.
  assign rx_reset = reset | rx_reset_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    active_q <= rx_active;
    if (reset) begin
      state_q    <= StIdle;
      rx_reset_q <= 1'b1;
      word_cnt_q <= '0;
      timer_q    <= '0;
      rec_cnt_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push_ok) level_q <= level_q - 1'b1;
      if (push_req && !push_ok) overflow_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          rx_reset_q <= 1'b0;
          if (rx_error) begin
            state_q    <= StRecover;
            rx_reset_q <= 1'b1;
            rec_cnt_q  <= RecoverLast;
          end else if (rise) begin
            state_q    <= StReceive;
            word_cnt_q <= '0;
            timer_q    <= '0;
          end
        end
        StReceive: begin
          if (rx_error || timeout) begin
            state_q    <= StRecover;
            rx_reset_q <= 1'b1;
            rec_cnt_q  <= RecoverLast;
          end else if (fall) begin
            state_q <= StIdle;
          end else if (rx_strobe) begin
            if (word_cnt_q != 9'h1FF) word_cnt_q <= word_cnt_q + 1'b1;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StRecover: begin
          if (rec_cnt_q == '0) begin
            rx_reset_q <= 1'b0;
            state_q    <= StIdle;
          end else begin
            rec_cnt_q <= rec_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/coax_rx_frame_ctrl.md
COAX_RX_FRAME_CTRL -- requirements
Module: coax_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter TIMEOUT_CLOCKS, default 256, max idle clocks inside a frame between word strobes.
REQ-003 SHALL have parameter RECOVER_CLOCKS, default 4, receiver-reset pulse length after an error.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx_active  input  1  receiver is inside a frame.
REQ-007 SHALL have port rx_strobe  input  1  one-cycle pulse: rx_data holds a completed 10-bit word.
REQ-008 SHALL have port rx_error  input  1  receiver is in its error state.
REQ-009 SHALL have port rx_data  input  10  received word, or error code while rx_error=1.
REQ-010 SHALL have port rx_reset  output  1  reset request to the receiver.
REQ-011 SHALL have port rd_en  input  1  host pops the head entry.
REQ-012 SHALL have port rd_data  output  11  head entry: bit10=marker flag, bits9:0=payload.
REQ-013 SHALL have port empty  output  1  FIFO empty.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-015 SHALL have port overflow  output  1  sticky: at least one entry dropped.

Function
REQ-016 SHALL implement states IDLE, RECEIVE, RECOVER.
REQ-017 IDLE: rx_active 0->1 (registered previous value) SHALL enter RECEIVE, clearing word counter and idle timer.
REQ-018 RECEIVE: each rx_strobe SHALL push {1'b0, rx_data} and increment the word counter (9-bit, saturates at 511).
REQ-019 RECEIVE: rx_active 1->0 with rx_error=0 SHALL push end marker {1'b1, 1'b0, count[8:0]} and enter IDLE.
REQ-020 RECEIVE: rx_error=1 SHALL push error marker {1'b1, 1'b1, 5'b0, rx_data[3:0]} and enter RECOVER; rx_error takes priority over rx_strobe and rx_active fall in the same cycle (the strobed word is dropped, overflow not set).
REQ-021 RECEIVE: idle timer counts cycles without rx_strobe; reaching TIMEOUT_CLOCKS SHALL push error marker with code 4'b1000 and enter RECOVER.
REQ-022 IDLE: rx_error=1 SHALL enter RECOVER without pushing a marker.
REQ-023 RECOVER: rx_reset SHALL be 1 for exactly RECOVER_CLOCKS cycles, then 0 and state IDLE; inputs ignored meanwhile.
REQ-024 rx_reset SHALL be 0 in IDLE and RECEIVE.
REQ-025 FIFO SHALL be first-word-fall-through: rd_data = head entry combinationally whenever empty=0; rd_data undefined-but-stable (all zero) when empty.
REQ-026 rd_en with empty=1 SHALL be ignored; no pointer or level change.
REQ-027 Push SHALL be accepted if level<DEPTH, or if level==DEPTH and a valid pop occurs in the same cycle.
REQ-028 Rejected push SHALL drop the entry and set overflow=1; overflow clears only on reset.
REQ-029 Simultaneous accepted push and pop SHALL leave level unchanged; pointers wrap modulo DEPTH.
REQ-030 level/empty SHALL update one cycle after the push/pop edge; pushed entry visible on rd_data the cycle after the push.

Reset
REQ-031 reset=1 SHALL force state IDLE, FIFO empty (level=0, empty=1), overflow=0, word counter and timers 0, within the same cycle edge.
REQ-032 rx_reset SHALL be 1 on every cycle reset is high and in the cycle after, abandoning any frame in progress without a marker.
REQ-033 Reset mid-RECOVER SHALL restart nothing: after release state is IDLE with rx_reset low after the one trailing cycle.

Verification
REQ-034 Frame: rx_active rise, 3 strobes 0x2A5,0x001,0x3FF, rx_active fall -> FIFO pops 0x2A5,0x001,0x3FF,0x403 (end marker count=3).
REQ-035 Error: in RECEIVE after 1 word, rx_error=1 with rx_data=0x002 -> pops word then 0x602; rx_reset high exactly 4 cycles, then IDLE.
REQ-036 Timeout: TIMEOUT_CLOCKS=8, rx_active rise, no strobes for 8 cycles -> marker 0x608 pushed, RECOVER entered.
REQ-037 Overflow: DEPTH=4, frame of 5 words, no reads -> level=4, overflow=1, first 4 words retained; same with rd_en on 5th strobe cycle -> no drop, overflow=0.
REQ-038 Empty read: rd_en=1 with empty=1 -> level stays 0, no pointer movement; subsequent push pops correctly.
REQ-039 Reset mid-frame: reset during RECEIVE with 2 entries queued -> empty=1, overflow=0, rx_reset=1, next frame received normally.
